// File: rtl/difftest_uart_tx_buffer.sv
// UART console byte buffer ahead of the difftest endpoint: valid/ready in, rate-limited pulses out.
// Optional macro DIFFTEST_UART_DROP_ON_FULL_EN: accept-and-drop on overflow instead of backpressure.
module difftest_uart_tx_buffer #(
    parameter int DEPTH     = 16,
    parameter int DRAIN_GAP = 0,
    parameter int CNT_W     = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_ch,
    output logic                       in_ready,
    input  logic                       hold,
    output logic                       difftest_uart_out_valid,
    output logic [7:0]                 difftest_uart_out_ch,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = (DRAIN_GAP > 0) ? $clog2(DRAIN_GAP + 1) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [GW-1:0] r_gap_cnt;
    logic          r_out_valid;
    logic [7:0]    r_out_ch;

    logic          w_full;
    logic          w_empty_fifo;
    logic          w_push;
    logic          w_pop;

    // Wrap bit distinguishes full from empty when the index bits coincide.
    assign w_full       = ((r_wptr ^ r_rptr) == PW'(DEPTH));
    assign w_empty_fifo = (r_wptr == r_rptr);
    assign w_push       = in_valid && !w_full && !reset;
    assign w_pop        = !w_empty_fifo && !hold && (r_gap_cnt == '0);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= in_ch;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_gap_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr      <= r_rptr + PW'(1);
                r_out_ch    <= r_mem[r_rptr[AW-1:0]];
                r_out_valid <= 1'b1;
                r_gap_cnt   <= GW'(DRAIN_GAP);
            end else begin
                r_out_valid <= 1'b0;
                if (r_gap_cnt != '0) begin
                    r_gap_cnt <= r_gap_cnt - GW'(1);
                end
            end
        end
    end

`ifdef DIFFTEST_UART_DROP_ON_FULL_EN
    logic             w_drop;
    logic [CNT_W-1:0] r_drop_count;

    assign in_ready = !reset;
    assign w_drop   = in_valid && w_full && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + CNT_W'(1);
        end
    end

    assign drop_count = r_drop_count;
`else
    assign in_ready   = !reset && !w_full;
    assign drop_count = '0;
`endif

    assign level                   = r_wptr - r_rptr;
    assign difftest_uart_out_valid = r_out_valid;
    assign difftest_uart_out_ch    = r_out_ch;
    assign empty                   = w_empty_fifo && !r_out_valid;

endmodule
